// File: rtl/hazard_forward_unit_pkg.sv
// Shared definitions for the ID-stage hazard / forwarding control.
//   REG_ADDR_WIDTH_DEF : default register-file address width
//   FWD_*              : encodings of the EX-stage operand multiplexer selects
package hazard_forward_unit_pkg;

  localparam int REG_ADDR_WIDTH_DEF = 5;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,  // operand from register file
    FWD_EXMEM = 2'b01,  // operand from EX/MEM ALU result
    FWD_MEMWB = 2'b10   // operand from MEM/WB write-back data
  } fwd_sel_e;

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// fwd_select: per-operand compare of one ID source register against the
// two in-flight destination entries (EX, MEM).
//   rs, rs_used, id_valid       : ID-stage source operand
//   ex_rd, ex_we, ex_load       : scoreboard entry of the instruction in EX
//   mem_rd, mem_we              : scoreboard entry of the instruction in MEM
//   sel                         : operand select for when this instruction is in EX
//   load_hit                    : operand depends on a load still in EX
module fwd_select
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs,
  input  logic                      rs_used,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_we,
  input  logic                      ex_load,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  input  logic                      mem_we,
  output logic [1:0]                sel,
  output logic                      load_hit
);

  logic reads_reg;
  logic ex_match;
  logic mem_match;

  // x0 is hardwired zero, so a read of it never depends on a producer.
  assign reads_reg = id_valid & rs_used & (rs != '0);
  assign ex_match  = reads_reg & ex_we  & (rs == ex_rd);
  assign mem_match = reads_reg & mem_we & (rs == mem_rd);
  assign load_hit  = ex_match & ex_load;

  // Youngest producer wins. A load in EX cannot forward; the top level
  // bubbles that case, so its select value is irrelevant.
  always_comb begin
    sel = FWD_RF;
    if (ex_match && !ex_load) begin
      sel = FWD_EXMEM;
    end else if (mem_match) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: ID-stage pipeline control for the 5-stage core.
// Tracks destination registers of the instructions in EX and MEM, produces
// registered EX operand selects and combinational stall / flush / bubble /
// freeze controls for the pipeline registers.
//   clk, reset (async, active low)
//   id_*            : instruction currently in ID
//   ex_branch_taken : taken branch/jump resolved in EX
//   dmem_stall      : data memory busy, whole pipeline freezes
//   stall_if, flush_if_id, bubble_ex, hold_ex_mem : pipeline controls
//   fwd_a_sel, fwd_b_sel : EX operand selects (registered)
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic                      ex_branch_taken,
  input  logic                      dmem_stall,
  output logic                      stall_if,
  output logic                      flush_if_id,
  output logic                      bubble_ex,
  output logic                      hold_ex_mem,
  output logic [1:0]                fwd_a_sel,
  output logic [1:0]                fwd_b_sel
);

  // Scoreboard entries for the instructions in EX and MEM.
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic                      ex_we;
  logic                      ex_load;
  logic [REG_ADDR_WIDTH-1:0] mem_rd;
  logic                      mem_we;

  logic [REG_ADDR_WIDTH-1:0] op_rs   [2];
  logic                      op_used [2];
  logic [1:0]                op_sel  [2];
  logic                      op_hit  [2];
  logic                      load_use;

  assign op_rs[0]   = id_rs1;
  assign op_rs[1]   = id_rs2;
  assign op_used[0] = id_rs1_used;
  assign op_used[1] = id_rs2_used;

  for (genvar gi = 0; gi < 2; gi++) begin : g_operand
    fwd_select #(
      .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_fwd_select (
      .rs       (op_rs[gi]),
      .rs_used  (op_used[gi]),
      .id_valid (id_valid),
      .ex_rd    (ex_rd),
      .ex_we    (ex_we),
      .ex_load  (ex_load),
      .mem_rd   (mem_rd),
      .mem_we   (mem_we),
      .sel      (op_sel[gi]),
      .load_hit (op_hit[gi])
    );
  end

  assign load_use = op_hit[0] | op_hit[1];

  // Priority: freeze > branch > load-use. All controls are forced low while
  // reset is asserted so the pipeline registers see no stray stall/flush.
  always_comb begin
    stall_if    = 1'b0;
    flush_if_id = 1'b0;
    bubble_ex   = 1'b0;
    hold_ex_mem = 1'b0;
    if (reset) begin
      if (dmem_stall) begin
        // EX stays held, so a taken branch in EX is re-presented once the
        // freeze ends and gets its flush then.
        stall_if    = 1'b1;
        hold_ex_mem = 1'b1;
      end else if (ex_branch_taken) begin
        flush_if_id = 1'b1;
        bubble_ex   = 1'b1;
      end else if (load_use) begin
        stall_if    = 1'b1;
        bubble_ex   = 1'b1;
      end
    end
  end

  // Scoreboard and select registers advance together with ID/EX and hold
  // during a data-memory freeze.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_rd     <= '0;
      ex_we     <= 1'b0;
      ex_load   <= 1'b0;
      mem_rd    <= '0;
      mem_we    <= 1'b0;
      fwd_a_sel <= FWD_RF;
      fwd_b_sel <= FWD_RF;
    end else if (!dmem_stall) begin
      mem_rd <= ex_rd;
      mem_we <= ex_we;
      if (bubble_ex) begin
        ex_rd     <= '0;
        ex_we     <= 1'b0;
        ex_load   <= 1'b0;
        fwd_a_sel <= FWD_RF;
        fwd_b_sel <= FWD_RF;
      end else begin
        ex_rd     <= id_rd;
        ex_we     <= id_reg_write & id_valid;
        ex_load   <= id_mem_read & id_valid;
        fwd_a_sel <= op_sel[0];
        fwd_b_sel <= op_sel[1];
      end
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed scenarios with
// literal expectations plus randomized traffic compared against a
// history-based model of the instructions in flight.
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0;
  logic [4:0] id_rs2 = '0;
  logic       id_rs1_used = 1'b0;
  logic       id_rs2_used = 1'b0;
  logic [4:0] id_rd = '0;
  logic       id_reg_write = 1'b0;
  logic       id_mem_read = 1'b0;
  logic       ex_branch_taken = 1'b0;
  logic       dmem_stall = 1'b0;
  logic       stall_if, flush_if_id, bubble_ex, hold_ex_mem;
  logic [1:0] fwd_a_sel, fwd_b_sel;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  hazard_forward_unit #(.REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken), .dmem_stall(dmem_stall),
    .stall_if(stall_if), .flush_if_id(flush_if_id), .bubble_ex(bubble_ex),
    .hold_ex_mem(hold_ex_mem), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // hist[0] = instruction now in EX, hist[1] = instruction now in MEM.
  // A bubble is an entry that writes nothing.
  typedef struct {
    logic [4:0] rd;
    bit         we;
    bit         load;
  } instr_t;

  instr_t hist[$];
  int     exp_fwd_a, exp_fwd_b;
  bit     e_stall, e_flush, e_bubble, e_hold;
  int     n_sel_a, n_sel_b;

  task automatic model_clear();
    instr_t none;
    none.rd = '0; none.we = 0; none.load = 0;
    hist.delete();
    hist.push_back(none);
    hist.push_back(none);
    exp_fwd_a = 0;
    exp_fwd_b = 0;
  endtask

  // Which stage (1 = EX, 2 = MEM) holds the youngest writer of rs;
  // a load still in EX is a load-use hazard instead.
  task automatic producer(input logic [4:0] rs, input bit used,
                          output int sel, output bit lu);
    sel = 0;
    lu  = 0;
    if (id_valid && used && rs != 0) begin
      for (int d = 0; d < 2; d++) begin
        if (hist[d].we && hist[d].rd == rs) begin
          if (hist[d].load && d == 0) lu = 1;
          else sel = d + 1;
          break;
        end
      end
    end
  endtask

  task automatic model_eval();
    bit lu_a, lu_b, lu;
    producer(id_rs1, id_rs1_used, n_sel_a, lu_a);
    producer(id_rs2, id_rs2_used, n_sel_b, lu_b);
    lu = lu_a | lu_b;
    if (!reset) begin
      e_stall = 0; e_flush = 0; e_bubble = 0; e_hold = 0;
    end else begin
      e_hold   = dmem_stall;
      e_stall  = dmem_stall || (!ex_branch_taken && lu);
      e_flush  = !dmem_stall && ex_branch_taken;
      e_bubble = !dmem_stall && (ex_branch_taken || lu);
    end
  endtask

  task automatic check(input string name, input logic [1:0] act, input int exp);
    checks++;
    if (act !== 2'(exp)) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic compare_model();
    model_eval();
    check("stall_if",    {1'b0, stall_if},    int'(e_stall));
    check("flush_if_id", {1'b0, flush_if_id}, int'(e_flush));
    check("bubble_ex",   {1'b0, bubble_ex},   int'(e_bubble));
    check("hold_ex_mem", {1'b0, hold_ex_mem}, int'(e_hold));
    check("fwd_a_sel",   fwd_a_sel, exp_fwd_a);
    check("fwd_b_sel",   fwd_b_sel, exp_fwd_b);
  endtask

  // Present one ID-stage cycle and compare against the model.
  task automatic cycle_begin(input bit v, input int rs1, input bit u1,
                             input int rs2, input bit u2, input int rd,
                             input bit rw, input bit mr, input bit br, input bit ds);
    id_valid = v; id_rs1 = 5'(rs1); id_rs1_used = u1;
    id_rs2 = 5'(rs2); id_rs2_used = u2; id_rd = 5'(rd);
    id_reg_write = rw; id_mem_read = mr;
    ex_branch_taken = br; dmem_stall = ds;
    #2;
    compare_model();
    $display("cyc %0d v=%0b rs1=%0d rs2=%0d rd=%0d rw=%0b ld=%0b br=%0b ds=%0b -> st=%0b fl=%0b bu=%0b ho=%0b fa=%0d fb=%0d",
             cyc, v, rs1, rs2, rd, rw, mr, br, ds,
             stall_if, flush_if_id, bubble_ex, hold_ex_mem, fwd_a_sel, fwd_b_sel);
  endtask

  // Clock edge: advance the model the same way the pipeline moves.
  task automatic cycle_end();
    instr_t ent;
    model_eval();
    @(posedge clk);
    cyc++;
    if (!reset) begin
      model_clear();
    end else if (!dmem_stall) begin
      ent.rd   = id_rd;
      ent.we   = !e_bubble && id_valid && id_reg_write;
      ent.load = !e_bubble && id_valid && id_mem_read;
      if (e_bubble) ent.rd = '0;
      hist.push_front(ent);
      void'(hist.pop_back());
      exp_fwd_a = e_bubble ? 0 : n_sel_a;
      exp_fwd_b = e_bubble ? 0 : n_sel_b;
    end
    #1;
  endtask

  task automatic nop_begin();
    cycle_begin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drop_reset();
    reset = 1'b0;
    model_clear();
    #1;
    compare_model();
  endtask

  initial begin
    model_clear();
    #12;
    compare_model();
    check("reset_fwd_a", fwd_a_sel, 0);
    check("reset_stall", {1'b0, stall_if}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // ALU chain: add x5 then sub reading x5 on rs1.
    cycle_begin(1, 1, 1, 2, 1, 5, 1, 0, 0, 0); cycle_end();
    cycle_begin(1, 5, 1, 3, 1, 9, 1, 0, 0, 0);
    check("alu_no_stall", {1'b0, stall_if}, 0);
    cycle_end();
    nop_begin();
    check("alu_fwd_a", fwd_a_sel, 1);
    cycle_end();

    // Distance 2 on rs2.
    cycle_begin(1, 1, 1, 2, 1, 6, 1, 0, 0, 0); cycle_end();
    cycle_begin(1, 1, 1, 2, 1, 12, 1, 0, 0, 0); cycle_end();
    cycle_begin(1, 3, 1, 6, 1, 13, 1, 0, 0, 0); cycle_end();
    nop_begin();
    check("dist2_fwd_b", fwd_b_sel, 2);
    cycle_end();

    // rd = x0 producer followed by x0 reader.
    cycle_begin(1, 1, 1, 2, 1, 0, 1, 0, 0, 0); cycle_end();
    cycle_begin(1, 0, 1, 0, 1, 14, 1, 0, 0, 0); cycle_end();
    nop_begin();
    check("x0_fwd_a", fwd_a_sel, 0);
    check("x0_fwd_b", fwd_b_sel, 0);
    cycle_end();

    // Load-use: lw x7 then add reading x7.
    cycle_begin(1, 1, 1, 0, 0, 7, 1, 1, 0, 0); cycle_end();
    cycle_begin(1, 7, 1, 2, 1, 15, 1, 0, 0, 0);
    check("lu_stall", {1'b0, stall_if}, 1);
    check("lu_bubble", {1'b0, bubble_ex}, 1);
    check("lu_flush", {1'b0, flush_if_id}, 0);
    cycle_end();
    cycle_begin(1, 7, 1, 2, 1, 15, 1, 0, 0, 0);
    check("lu_stall_once", {1'b0, stall_if}, 0);
    check("lu_bubble_once", {1'b0, bubble_ex}, 0);
    cycle_end();
    nop_begin();
    check("lu_fwd_a", fwd_a_sel, 2);
    cycle_end();

    // Branch overrides load-use.
    cycle_begin(1, 1, 1, 0, 0, 8, 1, 1, 0, 0); cycle_end();
    cycle_begin(1, 8, 1, 2, 1, 16, 1, 0, 1, 0);
    check("br_flush", {1'b0, flush_if_id}, 1);
    check("br_bubble", {1'b0, bubble_ex}, 1);
    check("br_stall", {1'b0, stall_if}, 0);
    cycle_end();
    nop_begin(); cycle_end();

    // Freeze for 3 cycles during a forwarding sequence.
    cycle_begin(1, 1, 1, 2, 1, 10, 1, 0, 0, 0); cycle_end();
    cycle_begin(1, 10, 1, 2, 1, 11, 1, 0, 0, 0); cycle_end();
    for (int k = 0; k < 3; k++) begin
      cycle_begin(1, 3, 1, 10, 1, 17, 1, 0, 0, 1);
      check("frz_hold", {1'b0, hold_ex_mem}, 1);
      check("frz_stall", {1'b0, stall_if}, 1);
      check("frz_fwd_a", fwd_a_sel, 1);
      cycle_end();
    end
    cycle_begin(1, 3, 1, 10, 1, 17, 1, 0, 0, 0);
    check("frz_release_stall", {1'b0, stall_if}, 0);
    check("frz_release_fwd_a", fwd_a_sel, 1);
    cycle_end();
    nop_begin();
    check("frz_fwd_b", fwd_b_sel, 2);
    cycle_end();

    // Reset asserted during a load-use stall.
    cycle_begin(1, 1, 1, 0, 0, 7, 1, 1, 0, 0); cycle_end();
    cycle_begin(1, 7, 1, 2, 1, 18, 1, 0, 0, 0);
    check("rst_pre_stall", {1'b0, stall_if}, 1);
    drop_reset();
    check("rst_stall", {1'b0, stall_if}, 0);
    check("rst_bubble", {1'b0, bubble_ex}, 0);
    cycle_end();
    reset = 1'b1;
    cycle_begin(1, 7, 1, 2, 1, 18, 1, 0, 0, 0);
    check("rst_after_stall", {1'b0, stall_if}, 0);
    cycle_end();
    nop_begin();
    check("rst_after_fwd_a", fwd_a_sel, 0);
    cycle_end();

    // Randomized traffic over a small register range to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      bit v, u1, u2, rw, mr, br, ds;
      int rs1, rs2, rd;
      v   = ($urandom_range(0, 9) != 0);
      rs1 = $urandom_range(0, 7);
      rs2 = $urandom_range(0, 7);
      u1  = ($urandom_range(0, 4) != 0);
      u2  = ($urandom_range(0, 2) != 0);
      rd  = $urandom_range(0, 7);
      rw  = ($urandom_range(0, 4) != 0);
      mr  = rw && ($urandom_range(0, 2) == 0);
      br  = ($urandom_range(0, 9) == 0);
      ds  = ($urandom_range(0, 6) == 0);
      cycle_begin(v, rs1, u1, rs2, u2, rd, rw, mr, br, ds);
      if ($urandom_range(0, 79) == 0) begin
        drop_reset();
        cycle_end();
        reset = 1'b1;
      end else begin
        cycle_end();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
